// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the UART transmitter.
//   tx_state_t - FSM state codes, also presented on STATUS. The codes match
//                the receiver (uart_fsm) so STATUS decodes the same on both
//                sides: IDLE=000, START=001, DATA=011, STOP=100 (010 unused).
//   cnt_width  - counter width for a modulo-n counter (at least 1 bit).
package uart_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_START = 3'b001,
    S_DATA  = 3'b011,
    S_STOP  = 3'b100
  } tx_state_t;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_baud.sv
// uart_tx_baud: CE-gated modulo-CLK_PER_BIT bit-period counter.
//   CLK      in  system clock
//   CE       in  clock enable; counter frozen when low
//   RESTART  in  synchronous restart to 0 (frame start, reset); wins over CE
//   TICK     out high in the CE cycle where the count is CLK_PER_BIT-1,
//                i.e. the last cycle of a bit period
module uart_tx_baud
  import uart_tx_pkg::*;
#(
  parameter int CLK_PER_BIT = 1600
) (
  input  logic CLK,
  input  logic CE,
  input  logic RESTART,
  output logic TICK
);

  localparam int CW = cnt_width(CLK_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESTART) begin
      cnt <= '0;
    end else if (CE) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign TICK = CE & (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1-style UART transmitter (start=0, data LSB first, stop=1).
//   CLK     in  system clock, all logic on posedge
//   CLR     in  synchronous active-high reset, overrides CE; aborts a frame
//   CE      in  clock enable; all state frozen when low, DONE forced low
//   DATA    in  byte to send, sampled only on an accepted WR
//   WR      in  write strobe, accepted when CE and the FSM is idle
//   TX      out serial line (registered), idle high
//   BUSY    out high from the cycle after acceptance until the frame ends
//   DONE    out one-CLK pulse on return to IDLE after the stop bit(s)
//   STATUS  out current FSM state code (see uart_tx_pkg)
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_PER_BIT = 1600,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 CE,
  input  logic [DATA_BITS-1:0] DATA,
  input  logic                 WR,
  output logic                 TX,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [2:0]           STATUS
);

  // One counter serves both data bits and stop bits (STOP_BITS <= DATA_BITS).
  localparam int BW = cnt_width(DATA_BITS);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bitcnt;
  logic                 tick;
  logic                 accept;

  assign accept = CE & WR & (state == S_IDLE);

  uart_tx_baud #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_baud (
    .CLK    (CLK),
    .CE     (CE),
    .RESTART(CLR | accept),
    .TICK   (tick)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state  <= S_IDLE;
      TX     <= 1'b1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      DONE <= 1'b0;
      if (CE) begin
        case (state)
          S_IDLE: begin
            TX   <= 1'b1;
            BUSY <= 1'b0;
            if (WR) begin
              shreg  <= DATA;
              bitcnt <= '0;
              state  <= S_START;
              TX     <= 1'b0;
              BUSY   <= 1'b1;
            end
          end
          S_START: begin
            if (tick) begin
              state  <= S_DATA;
              TX     <= shreg[0];
              shreg  <= shreg >> 1;
              bitcnt <= '0;
            end
          end
          S_DATA: begin
            if (tick) begin
              if (bitcnt == LAST_DATA) begin
                state  <= S_STOP;
                TX     <= 1'b1;
                bitcnt <= '0;
              end else begin
                TX     <= shreg[0];
                shreg  <= shreg >> 1;
                bitcnt <= bitcnt + 1'b1;
              end
            end
          end
          S_STOP: begin
            if (tick) begin
              if (bitcnt == LAST_STOP) begin
                state <= S_IDLE;
                BUSY  <= 1'b0;
                DONE  <= 1'b1;
              end else begin
                bitcnt <= bitcnt + 1'b1;
              end
            end
          end
          default: begin
            state <= S_IDLE;
            TX    <= 1'b1;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign STATUS = state;

endmodule
